// File: rtl/fw_ip4_scan_ctrl.sv
// fw_ip4_scan_ctrl
//   Firmware-driven scan-chain sequencer. Firmware fills a TX bit buffer,
//   issues start, and the block shifts bit_count bits out LSB-of-word-0
//   first on fw_scan_in with a generated scan clock. It captures
//   fw_scan_out into an RX buffer on the last fw_clk of each scan-clock
//   high phase, then pulses fw_scan_load for one half-period.
//
// Ports
//   fw_clk, fw_rst              clock, synchronous active-high reset
//   start, bit_count,           sequence request; count and half-period
//   half_period                 are sampled with start
//   status_clear                clears done/error (a same-cycle set wins)
//   wr_en, wr_addr, wr_data     TX buffer word write (ignored while busy)
//   rd_addr, rd_data            RX buffer word read, one cycle latency
//   fw_scan_in/clk/load         registered scan outputs to the DUT
//   fw_scan_out                 serial return data, already in fw_clk domain
//   busy, done, error           status
module fw_ip4_scan_ctrl #(
    parameter int MAX_BITS = 256,
    parameter int AW       = 3
) (
    input  logic          fw_clk,
    input  logic          fw_rst,
    input  logic          start,
    input  logic          status_clear,
    input  logic [8:0]    bit_count,
    input  logic [7:0]    half_period,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    output logic          fw_scan_in,
    output logic          fw_scan_clk,
    output logic          fw_scan_load,
    input  logic          fw_scan_out,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam int         WORDS = MAX_BITS / 32;
    localparam int         IW    = $clog2(MAX_BITS);
    localparam logic [8:0] MAX_N = 9'(MAX_BITS);

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD} state_t;

    state_t state, state_nxt;

    // Packed word arrays: flat bit i is word i/32, bit i%32.
    logic [WORDS-1:0][31:0] tx_mem, rx_mem;

    logic [IW-1:0] idx, idx_nxt, last_idx;
    logic [7:0]    phase, phase_nxt, h_m1;
    logic          start_ok, start_bad, phase_end, capture, done_set;
    logic          scan_in_nxt, scan_clk_nxt, scan_load_nxt;
    logic [7:0]    h_eff;

    assign busy      = (state != IDLE);
    assign start_ok  = start && (state == IDLE) && (bit_count != 9'd0) && (bit_count <= MAX_N);
    assign start_bad = start && (state == IDLE) && !((bit_count != 9'd0) && (bit_count <= MAX_N));
    assign phase_end = (phase == h_m1);
    assign done_set  = (state == LOAD) && phase_end;
    assign h_eff     = (half_period == 8'd0) ? 8'd1 : half_period;

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        phase_nxt     = phase;
        capture       = 1'b0;
        scan_in_nxt   = 1'b0;
        scan_clk_nxt  = 1'b0;
        scan_load_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = SHIFT_LO;
                    idx_nxt   = '0;
                    phase_nxt = 8'd0;
                end
            end
            SHIFT_LO: begin
                phase_nxt = phase + 8'd1;
                if (phase_end) begin
                    phase_nxt = 8'd0;
                    state_nxt = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                phase_nxt = phase + 8'd1;
                if (phase_end) begin
                    phase_nxt = 8'd0;
                    capture   = 1'b1;
                    if (idx == last_idx) begin
                        state_nxt = LOAD;
                    end else begin
                        idx_nxt   = idx + IW'(1);
                        state_nxt = SHIFT_LO;
                    end
                end
            end
            LOAD: begin
                phase_nxt = phase + 8'd1;
                if (phase_end) begin
                    phase_nxt = 8'd0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Scan outputs are decoded from the next state so the registered
        // pins line up with the state they describe.
        case (state_nxt)
            SHIFT_LO: scan_in_nxt = tx_mem[idx_nxt[IW-1:5]][idx_nxt[4:0]];
            SHIFT_HI: begin
                scan_in_nxt  = tx_mem[idx_nxt[IW-1:5]][idx_nxt[4:0]];
                scan_clk_nxt = 1'b1;
            end
            LOAD:     scan_load_nxt = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge fw_clk) begin
        if (fw_rst) begin
            state        <= IDLE;
            idx          <= '0;
            last_idx     <= '0;
            phase        <= 8'd0;
            h_m1         <= 8'd0;
            tx_mem       <= '0;
            rx_mem       <= '0;
            rd_data      <= 32'd0;
            fw_scan_in   <= 1'b0;
            fw_scan_clk  <= 1'b0;
            fw_scan_load <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            phase        <= phase_nxt;
            fw_scan_in   <= scan_in_nxt;
            fw_scan_clk  <= scan_clk_nxt;
            fw_scan_load <= scan_load_nxt;
            rd_data      <= rx_mem[rd_addr];

            if (start_ok) begin
                last_idx <= IW'(bit_count - 9'd1);
                h_m1     <= h_eff - 8'd1;
            end

            if (wr_en && (state == IDLE))
                tx_mem[wr_addr] <= wr_data;

            if (capture)
                rx_mem[idx[IW-1:5]][idx[4:0]] <= fw_scan_out;

            // Set events take priority over clears.
            if (done_set)
                done <= 1'b1;
            else if (status_clear || start_ok)
                done <= 1'b0;

            if (start_bad)
                error <= 1'b1;
            else if (status_clear || start_ok)
                error <= 1'b0;
        end
    end

endmodule
